digital_in_report: RTL and testbench

- Input-direction counterpart of the command-driven GPIO output block. It samples external digital inputs on a systime schedule.
- It answers host read commands synchronously over the param bus.
- It pushes unsolicited change reports to the host through the involuntary-request path.
- It sits on the same command dispatcher (cmd/arg_data/cmd_done), param bus (param_data/param_write) and invol_req/invol_grant arbiter as the other peripheral blocks.

---
 rtl/digital_in_report_if.sv | 24 ++
 rtl/digital_in_report.sv | 220 ++++++++++++++++++++++
 tb/tb_digital_in_report.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/digital_in_report_if.sv
// Command/param-bus/involuntary-request bundle shared by peripheral blocks.
// slave = peripheral side, master = dispatcher/arbiter side.
interface digital_in_report_if #(
  parameter int CMD_BITS = 8
) ();
  logic [31:0]         arg_data;
  logic                arg_advance;
  logic [CMD_BITS-1:0] cmd;
  logic                cmd_ready;
  logic                cmd_done;
  logic [31:0]         param_data;
  logic                param_write;
  logic                invol_req;
  logic                invol_grant;

  modport slave (
    input  arg_data, cmd, cmd_ready, invol_grant,
    output arg_advance, cmd_done, param_data, param_write, invol_req
  );
  modport master (
    output arg_data, cmd, cmd_ready, invol_grant,
    input  arg_advance, cmd_done, param_data, param_write, invol_req
  );
endinterface

// File: rtl/digital_in_report.sv
// Digital input block: host reads, systime-scheduled sampling, unsolicited change reports.
// Optional input debounce enabled by defining DIGITAL_IN_DEBOUNCE_EN.
module digital_in_report #(
  parameter int                NGPI                  = 8,
  parameter int                CMD_BITS              = 8,
  parameter logic [CMD_BITS-1:0] CMD_CONFIG_DIGITAL_IN = 5,
  parameter logic [CMD_BITS-1:0] CMD_QUERY_DIGITAL_IN  = 6,
  parameter logic [CMD_BITS-1:0] CMD_READ_DIGITAL_IN   = 7,
  parameter int                DEBOUNCE_CYCLES       = 16,
  localparam int               CH_BITS               = $clog2(NGPI)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         systime,
  input  logic [NGPI-1:0]     gpi,
  input  logic                shutdown,
  digital_in_report_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, CFG_1, QRY_1, QRY_2, RD_1, RD_2, RD_3, REP_1, REP_2, REP_3
  } state_e;

  if (NGPI < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("digital_in_report: NGPI must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  state_e state_q, state_d;
  logic [CH_BITS-1:0] ch_q, ch_d, sel_q, sel_d, low;
  logic ok_q, ok_d, rep_val_q, rep_val_d, resamp_q, resamp_d;
  logic [31:0] rep_time_q, rep_time_d, rd_time_q, rd_time_d;
  logic cmd_done_q, cmd_done_d, pw_q, pw_d;
  logic [31:0] pdata_q, pdata_d;
  logic [NGPI-1:0] sync1_q, sync2_q, in_val, eff, hit;
  logic [NGPI-1:0] en_q, en_d, pend_q, pend_d, inv_q, inv_d;
  logic [NGPI-1:0] sv_q, sv_d, lrv_q, lrv_d, lrval_q, lrval_d;
  logic [NGPI-1:0][31:0] nt_q, nt_d, rest_q, rest_d, st_q, st_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpi;
      sync2_q <= sync1_q;
    end
  end

`ifdef DIGITAL_IN_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [NGPI-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [NGPI-1:0] db_q, db_d;

  // Counter runs only while the synchronized input disagrees with the debounced value.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < NGPI; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      db_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign in_val = db_q;
`else
  assign in_val = sync2_q;
`endif

  assign eff = in_val ^ inv_q;
  assign bus.arg_advance = 1'b1;
  assign bus.cmd_done    = cmd_done_q;
  assign bus.param_write = pw_q;
  assign bus.param_data  = pdata_q;
  assign bus.invol_req   = (state_q == IDLE) && (|pend_q) && !shutdown;

  always_comb begin
    low = '0;
    for (int i = NGPI - 1; i >= 0; i--) begin
      if (pend_q[i]) low = CH_BITS'(i);
    end
    for (int i = 0; i < NGPI; i++) hit[i] = en_q[i] && (systime == nt_q[i]);
  end

  always_comb begin
    state_d = state_q;   ch_d = ch_q;       ok_d = ok_q;
    sel_d = sel_q;       rep_val_d = rep_val_q;
    rep_time_d = rep_time_q;  resamp_d = resamp_q;  rd_time_d = rd_time_q;
    cmd_done_d = 1'b0;   pw_d = 1'b0;       pdata_d = pdata_q;
    en_d = en_q;  pend_d = pend_q;  inv_d = inv_q;  sv_d = sv_q;
    lrv_d = lrv_q;  lrval_d = lrval_q;  nt_d = nt_q;  rest_d = rest_q;  st_d = st_q;

    // Scheduled sampling first so that command writes below take precedence.
    for (int i = 0; i < NGPI; i++) begin
      if (hit[i]) begin
        sv_d[i] = eff[i];
        st_d[i] = systime;
        nt_d[i] = nt_q[i] + rest_q[i];
        if (rest_q[i] == '0) en_d[i] = 1'b0;
        if (!lrv_q[i] || (eff[i] != lrval_q[i])) pend_d[i] = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.invol_req && bus.invol_grant) begin
          // Snapshot the report so later samples cannot tear it.
          sel_d      = low;
          rep_val_d  = sv_q[low];
          rep_time_d = st_q[low];
          resamp_d   = hit[low];
          state_d    = REP_1;
        end else if (bus.cmd_ready) begin
          ch_d = bus.arg_data[CH_BITS-1:0];
          ok_d = bus.arg_data < 32'(NGPI);
          if (bus.cmd == CMD_CONFIG_DIGITAL_IN)     state_d = CFG_1;
          else if (bus.cmd == CMD_QUERY_DIGITAL_IN) state_d = QRY_1;
          else if (bus.cmd == CMD_READ_DIGITAL_IN && bus.arg_data < 32'(NGPI)) state_d = RD_1;
          else cmd_done_d = 1'b1;
        end
      end
      CFG_1: begin
        if (ok_q) begin
          inv_d[ch_q]  = bus.arg_data[0];
          en_d[ch_q]   = 1'b0;
          pend_d[ch_q] = 1'b0;
          lrv_d[ch_q]  = 1'b0;
        end
        cmd_done_d = 1'b1;
        state_d    = IDLE;
      end
      QRY_1: begin
        if (ok_q) nt_d[ch_q] = bus.arg_data;
        state_d = QRY_2;
      end
      QRY_2: begin
        if (ok_q) begin
          rest_d[ch_q] = bus.arg_data;
          en_d[ch_q]   = !shutdown;
        end
        cmd_done_d = 1'b1;
        state_d    = IDLE;
      end
      RD_1: begin
        rd_time_d = systime;
        pw_d      = 1'b1;
        pdata_d   = 32'(ch_q);
        state_d   = RD_2;
      end
      RD_2: begin
        pw_d    = 1'b1;
        pdata_d = rd_time_q;
        state_d = RD_3;
      end
      RD_3: begin
        pw_d       = 1'b1;
        pdata_d    = {31'b0, eff[ch_q]};
        cmd_done_d = 1'b1;
        state_d    = IDLE;
      end
      REP_1: begin
        pw_d    = 1'b1;
        pdata_d = 32'(sel_q);
        if (hit[sel_q]) resamp_d = 1'b1;
        state_d = REP_2;
      end
      REP_2: begin
        pw_d    = 1'b1;
        pdata_d = rep_time_q;
        if (hit[sel_q]) resamp_d = 1'b1;
        state_d = REP_3;
      end
      REP_3: begin
        pw_d           = 1'b1;
        pdata_d        = {31'b0, rep_val_q};
        pend_d[sel_q]  = resamp_q || hit[sel_q];
        lrv_d[sel_q]   = 1'b1;
        lrval_d[sel_q] = rep_val_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (shutdown) begin
      en_d   = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  ch_q <= '0;  ok_q <= 1'b0;  sel_q <= '0;
      rep_val_q <= 1'b0;  rep_time_q <= '0;  resamp_q <= 1'b0;  rd_time_q <= '0;
      cmd_done_q <= 1'b0;  pw_q <= 1'b0;  pdata_q <= '0;
      en_q <= '0;  pend_q <= '0;  inv_q <= '0;  sv_q <= '0;
      lrv_q <= '0;  lrval_q <= '0;  nt_q <= '0;  rest_q <= '0;  st_q <= '0;
    end else begin
      state_q <= state_d;  ch_q <= ch_d;  ok_q <= ok_d;  sel_q <= sel_d;
      rep_val_q <= rep_val_d;  rep_time_q <= rep_time_d;  resamp_q <= resamp_d;
      rd_time_q <= rd_time_d;
      cmd_done_q <= cmd_done_d;  pw_q <= pw_d;  pdata_q <= pdata_d;
      en_q <= en_d;  pend_q <= pend_d;  inv_q <= inv_d;  sv_q <= sv_d;
      lrv_q <= lrv_d;  lrval_q <= lrval_d;  nt_q <= nt_d;  rest_q <= rest_d;  st_q <= st_d;
    end
  end
endmodule

// File: tb/tb_digital_in_report.sv
// Directed bench for digital_in_report: reads, scheduled reports, priority, wrap, shutdown, reset.
module tb_digital_in_report;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] systime;
  logic [7:0]  gpi;
  logic        shutdown;
  int          n_assert = 0;
  int          n_fail   = 0;

  digital_in_report_if #(.CMD_BITS(8)) bus ();

  digital_in_report dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .systime  (systime),
    .gpi      (gpi),
    .shutdown (shutdown),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a command; returns right after the edge where cmd_done becomes visible
  // (for query/config). n = number of argument words.
  task automatic send(input logic [7:0] op, input logic [31:0] a0, a1, a2, input int n);
    bus.cmd = op; bus.cmd_ready = 1'b1; bus.arg_data = a0;
    tick();
    bus.cmd_ready = 1'b0;
    if (n > 1) begin bus.arg_data = a1; tick(); end
    if (n > 2) begin bus.arg_data = a2; tick(); end
  endtask

  task automatic grant_report(input string tag, input logic [31:0] w0, w1, w2);
    bus.invol_grant = 1'b1;
    tick();
    bus.invol_grant = 1'b0;
    tick(); chk({tag, "_w0"}, {bus.param_write, bus.param_data[30:0]}, {1'b1, w0[30:0]});
    tick(); chk({tag, "_w1"}, bus.param_data, w1);
    tick(); chk({tag, "_w2"}, {bus.param_write, bus.param_data[30:0]}, {1'b1, w2[30:0]});
  endtask

  initial begin
    rst_n = 1'b0; systime = 0; gpi = 8'hD6; shutdown = 1'b0;
    bus.cmd = '0; bus.cmd_ready = 1'b0; bus.arg_data = '0; bus.invol_grant = 1'b0;
    tick(); tick();
    chk("rst_outputs", {bus.cmd_done, bus.param_write, bus.invol_req}, 3'b000);
    chk("rst_pdata", bus.param_data, 0);
    chk("arg_advance", bus.arg_advance, 1);
    rst_n = 1'b1;
    tick(); tick(); tick();

    // Config ch3 invert, then read it back with input low.
    send(8'd5, 3, 1, 0, 2);
    chk("cfg_done", bus.cmd_done, 1);
    tick();
    chk("cfg_done_pulse", bus.cmd_done, 0);
    systime = 1234;
    send(8'd7, 3, 0, 0, 1);
    tick(); chk("rd_w0", {bus.param_write, bus.cmd_done, bus.param_data[29:0]}, {2'b10, 30'd3});
    tick(); chk("rd_w1", {bus.param_write, bus.cmd_done, bus.param_data[29:0]}, {2'b10, 30'd1234});
    tick(); chk("rd_w2", {bus.param_write, bus.cmd_done, bus.param_data[29:0]}, {2'b11, 30'd1});
    tick(); chk("rd_end", {bus.param_write, bus.cmd_done}, 2'b00);

    // Unknown opcode completes next cycle.
    send(8'd9, 0, 0, 0, 1);
    chk("bad_op_done", {bus.cmd_done, bus.param_write}, 2'b10);

    // Periodic query on ch1.
    systime = 500;
    send(8'd6, 1, 1000, 100, 3);
    chk("qry_done", bus.cmd_done, 1);
    chk("qry_noreq", bus.invol_req, 0);
    systime = 1000; tick();
    chk("ch1_req", bus.invol_req, 1);
    systime = 1001;
    grant_report("ch1_r1", 1, 1000, 1);
    tick(); chk("ch1_req_clr", bus.invol_req, 0);
    systime = 1100; tick(); systime = 1101;
    chk("ch1_same_1100", bus.invol_req, 0);
    systime = 1200; tick(); systime = 1201;
    chk("ch1_same_1200", bus.invol_req, 0);
    gpi[1] = 1'b0; tick(); tick(); tick();
    systime = 1300; tick(); systime = 1301;
    chk("ch1_chg_req", bus.invol_req, 1);
    grant_report("ch1_r2", 1, 1300, 0);
    tick();
    send(8'd5, 1, 0, 0, 2);   // disable ch1
    tick();

    // ch2 and ch5 pending together: lowest index first.
    systime = 1500;
    send(8'd6, 2, 2000, 0, 3); tick();
    send(8'd6, 5, 2000, 0, 3); tick();
    systime = 2000; tick(); systime = 2001;
    grant_report("prio_ch2", 2, 2000, 1);
    tick(); chk("prio_req_ch5", bus.invol_req, 1);
    grant_report("prio_ch5", 5, 2000, 0);
    tick(); chk("prio_req_clr", bus.invol_req, 0);

    // Schedule wrap on ch4.
    systime = 32'hFFFF_FF00;
    send(8'd6, 4, 32'hFFFF_FFF0, 32'h20, 3); tick();
    systime = 32'hFFFF_FFF0; tick(); systime = 32'hFFFF_FFF1;
    grant_report("wrap_r1", 4, 32'hFFFF_FFF0, 1);
    gpi[4] = 1'b0; systime = 32'h5; tick(); tick(); tick();
    systime = 32'h10; tick(); systime = 32'h11;
    chk("wrap_req", bus.invol_req, 1);
    grant_report("wrap_r2", 4, 32'h10, 0);
    tick();
    send(8'd5, 4, 0, 0, 2); tick();

    // Shutdown before grant drops the request; no report.
    systime = 2900;
    send(8'd6, 1, 3000, 0, 3); tick();
    systime = 3000; tick(); systime = 3001;
    chk("sd_pre_req", bus.invol_req, 1);
    shutdown = 1'b1; #1;
    chk("sd_req_drop", bus.invol_req, 0);
    bus.invol_grant = 1'b1; tick();
    chk("sd_no_rep1", bus.param_write, 0);
    tick(); chk("sd_no_rep2", bus.param_write, 0);
    bus.invol_grant = 1'b0; shutdown = 1'b0; tick();
    chk("sd_pend_clr", bus.invol_req, 0);

    // Shutdown during REP_2: report still completes.
    systime = 3050;
    send(8'd6, 6, 3100, 0, 3); tick();
    systime = 3100; tick(); systime = 3101;
    bus.invol_grant = 1'b1; tick(); bus.invol_grant = 1'b0;
    tick(); chk("sd_rep_w0", bus.param_data, 6);
    shutdown = 1'b1;
    tick(); chk("sd_rep_w1", bus.param_data, 3100);
    tick(); chk("sd_rep_w2", {bus.param_write, bus.param_data[30:0]}, {1'b1, 31'd1});
    shutdown = 1'b0; tick();

    // Out-of-range read.
    send(8'd7, 9, 0, 0, 1);
    chk("oor_done", {bus.cmd_done, bus.param_write}, 2'b10);
    tick(); chk("oor_end", {bus.cmd_done, bus.param_write}, 2'b00);

    // Reset in the middle of a report.
    systime = 3150;
    send(8'd6, 7, 3200, 0, 3); tick();
    systime = 3200; tick(); systime = 3201;
    bus.invol_grant = 1'b1; tick(); bus.invol_grant = 1'b0;
    tick(); chk("rst_mid_w0", bus.param_data, 7);
    rst_n = 1'b0; #1;
    chk("rst_mid_flags", {bus.cmd_done, bus.param_write, bus.invol_req}, 3'b000);
    chk("rst_mid_pdata", bus.param_data, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
